// File: rtl/qoa_lms_recon.sv
// qoa_lms_recon: QOA LMS predictor and sample reconstruction.
//
// Accepts one dequantized residual per handshake. It runs a 4-tap LMS dot
// product, one multiply per cycle, then adds the residual to the prediction
// and saturates the result to 16 bits. It adapts the weights, shifts the
// history and presents the sample on a valid/ready output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   lms_load/idx/data   IDLE-only write of history[0..3] (idx 0-3) or weight[0..3] (idx 4-7)
//   res_valid/ready     residual input handshake, res_data is signed 16-bit
//   smp_valid/ready     sample output handshake, smp_data is signed 16-bit PCM
//   busy                high whenever the block is not idle
module qoa_lms_recon (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lms_load,
  input  logic [2:0]  lms_idx,
  input  logic [15:0] lms_data,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  output logic        res_ready,
  output logic        smp_valid,
  output logic [15:0] smp_data,
  input  logic        smp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMac, StRecon, StOut} state_e;

  state_e             r_state;
  logic signed [15:0] r_hist   [4];
  logic signed [23:0] r_weight [4];
  logic signed [41:0] r_acc;
  logic signed [15:0] r_res;
  logic [1:0]         r_idx;
  logic [15:0]        r_smp;
  logic               r_smp_valid;

  logic signed [39:0] w_prod;
  logic signed [41:0] w_sum;
  logic signed [15:0] w_smp;
  logic signed [15:0] w_delta;
  logic signed [23:0] w_wnext [4];

  always_comb begin
    w_prod  = 40'(r_hist[r_idx]) * 40'(r_weight[r_idx]);
    // r_acc is final by RECON; the prediction is its arithmetic shift by 13
    w_sum   = (r_acc >>> 13) + 42'(r_res);
    if (w_sum > 42'sd32767) begin
      w_smp = 16'sh7fff;
    end else if (w_sum < -42'sd32768) begin
      w_smp = -16'sh8000;
    end else begin
      w_smp = w_sum[15:0];
    end
    w_delta = r_res >>> 4;
    // Weight adaptation uses the pre-shift history; the sum wraps at 24 bits
    for (int i = 0; i < 4; i++) begin
      w_wnext[i] = r_weight[i] + (r_hist[i][15] ? -24'(w_delta) : 24'(w_delta));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_res       <= '0;
      r_idx       <= '0;
      r_smp       <= '0;
      r_smp_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_hist[i]   <= '0;
        r_weight[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (lms_load) begin
            if (lms_idx[2]) begin
              r_weight[lms_idx[1:0]] <= 24'($signed(lms_data));
            end else begin
              r_hist[lms_idx[1:0]] <= $signed(lms_data);
            end
          end else if (res_valid) begin
            r_res   <= $signed(res_data);
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= StMac;
          end
        end
        StMac: begin
          r_acc <= r_acc + 42'(w_prod);
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_state <= StRecon;
          end
        end
        StRecon: begin
          r_smp       <= w_smp;
          r_smp_valid <= 1'b1;
          for (int i = 0; i < 4; i++) begin
            r_weight[i] <= w_wnext[i];
          end
          r_hist[0] <= r_hist[1];
          r_hist[1] <= r_hist[2];
          r_hist[2] <= r_hist[3];
          r_hist[3] <= w_smp;
          r_state   <= StOut;
        end
        StOut: begin
          if (smp_ready) begin
            r_smp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Residual is only taken when the load port is quiet, so loads win in IDLE
  assign res_ready = (r_state == StIdle) && !lms_load;
  assign busy      = (r_state != StIdle);
  assign smp_valid = r_smp_valid;
  assign smp_data  = r_smp;

endmodule
